// File: rtl/ahb_lite_mem_slave.sv
// ahb_lite_mem_slave
//   Parametrised AHB-Lite memory slave. Single-cycle or wait-stated OKAY
//   transfers, byte-lane writes, and a two-cycle ERROR response for
//   out-of-range, oversized or misaligned transfers.
//
//   Optional feature macro: AHB_MEM_PRIV_WR_EN
//     defined   -> user-mode writes (HPROT[1]=0) get an ERROR response
//     undefined -> HPROT is ignored
//
// Ports
//   HCLK       in   clock, rising edge
//   HRESETn    in   asynchronous active-low reset
//   HSEL       in   slave select
//   HADDR      in   byte address [ADDR_W]
//   HWRITE     in   1 = write
//   HSIZE      in   log2 of transfer bytes
//   HBURST     in   burst type (ignored, every beat is independent)
//   HPROT      in   protection control
//   HTRANS     in   IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
//   HWDATA     in   write data, data phase [DATA_W]
//   HREADY     in   bus ready
//   HRDATA     out  read data [DATA_W]
//   HREADYOUT  out  slave ready
//   HRESP      out  0 = OKAY, 1 = ERROR
//
// State   | meaning
// IDLE    | no data phase in progress
// WAIT    | OKAY data phase stalled, HREADYOUT low
// DATA    | final OKAY data phase cycle, write commits at its end
// ERR1    | first ERROR cycle, HREADYOUT low
// ERR2    | second ERROR cycle, HREADYOUT high
module ahb_lite_mem_slave #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                MEM_DEPTH   = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [1:0]        HTRANS,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int                BYTES    = DATA_W / 8;
  localparam int                LANE_W   = $clog2(BYTES);
  localparam int                IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0]   SPAN     = (ADDR_W+1)'(MEM_DEPTH * BYTES);
  localparam logic [2:0]        MAX_SIZE = 3'(LANE_W);
  localparam logic [2:0]        WS_LAST  = 3'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t             state_q;
  logic               hreadyout_q;
  logic               hresp_q;
  logic [2:0]         cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [LANE_W-1:0]  lane_q;
  logic [2:0]         size_q;
  logic               write_q;

  logic [DATA_W-1:0]  mem [MEM_DEPTH];

  // Address-phase decode and error classification
  logic [ADDR_W-1:0]  offset;
  logic               in_range;
  logic [2:0]         align_mask;
  logic               size_bad;
  logic               misaligned;
  logic               priv_bad;
  logic               xfer_err;
  logic               accept;

  assign offset   = HADDR - BASE_ADDR;
  assign in_range = (HADDR >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign size_bad = HSIZE > MAX_SIZE;

  always_comb begin
    align_mask = 3'b111;
    case (HSIZE)
      3'd0:    align_mask = 3'b000;
      3'd1:    align_mask = 3'b001;
      3'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign misaligned = |(HADDR[2:0] & align_mask);

`ifdef AHB_MEM_PRIV_WR_EN
  assign priv_bad = HWRITE & ~HPROT[1];
`else
  assign priv_bad = 1'b0;
`endif

  assign xfer_err = ~in_range | size_bad | misaligned | priv_bad;
  assign accept   = HSEL & HREADY & HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == WS_LAST) begin
            state_q     <= ST_DATA;
            hreadyout_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        // IDLE, DATA and ERR2 all end with HREADYOUT high, so each may
        // take a new address phase.
        default: begin
          if (accept) begin
            idx_q   <= HADDR[LANE_W +: IDX_W];
            lane_q  <= HADDR[LANE_W-1:0];
            size_q  <= HSIZE;
            write_q <= HWRITE;
            if (xfer_err) begin
              state_q     <= ST_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state_q     <= ST_WAIT;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
              cnt_q       <= '0;
            end else begin
              state_q     <= ST_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
            end
          end else begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Byte strobes: 2^size contiguous lanes starting at the aligned lane.
  logic [7:0]       strb_base;
  logic [BYTES-1:0] strb;

  always_comb begin
    strb_base = 8'hFF;
    case (size_q)
      3'd0:    strb_base = 8'h01;
      3'd1:    strb_base = 8'h03;
      3'd2:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
    strb = BYTES'(strb_base << lane_q);
  end

  // Memory is not reset; an async reset forces IDLE, so a pending write
  // never reaches its commit edge.
  always_ff @(posedge HCLK) begin
    if (state_q == ST_DATA && write_q) begin
      for (int b = 0; b < BYTES; b++) begin
        if (strb[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Combinational read keeps write-then-read of one address hazard-free.
  assign HRDATA    = (state_q == ST_DATA) ? mem[idx_q] : '0;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
module tb_ahb_lite_mem_slave;

  localparam logic [31:0] BASE = 32'h0000_1000;

`ifdef AHB_MEM_PRIV_WR_EN
  localparam logic USER_WR_ERR = 1'b1;
`else
  localparam logic USER_WR_ERR = 1'b0;
`endif

  logic        hclk;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hresp;
  int          which;

  logic        hsel0, hsel2, hsel3;
  logic [31:0] rdata0, rdata2, rdata3;
  logic        rdy0, rdy2, rdy3;
  logic        resp0, resp2, resp3;

  int n_assert = 0;
  int n_fail   = 0;

  assign hsel0 = hsel && (which == 0);
  assign hsel2 = hsel && (which == 1);
  assign hsel3 = hsel && (which == 2);

  // Simple interconnect: the selected slave drives the shared ready/response.
  assign hready = (which == 0) ? rdy0   : (which == 1) ? rdy2   : rdy3;
  assign hrdata = (which == 0) ? rdata0 : (which == 1) ? rdata2 : rdata3;
  assign hresp  = (which == 0) ? resp0  : (which == 1) ? resp2  : resp3;

  ahb_lite_mem_slave #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256),
                       .BASE_ADDR(BASE), .WAIT_STATES(0)) u0 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel0), .HADDR(haddr),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0));

  ahb_lite_mem_slave #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256),
                       .BASE_ADDR(BASE), .WAIT_STATES(2)) u2 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel2), .HADDR(haddr),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(rdata2), .HREADYOUT(rdy2), .HRESP(resp2));

  ahb_lite_mem_slave #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256),
                       .BASE_ADDR(BASE), .WAIT_STATES(3)) u3 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel3), .HADDR(haddr),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HTRANS(htrans), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(rdata3), .HREADYOUT(rdy3), .HRESP(resp3));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_bus();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    haddr  = 32'h0;
    hsize  = 3'd2;
    hburst = 3'd0;
    hprot  = 4'b0011;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [3:0] prot);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
    hprot  = prot;
  endtask

  // One isolated transfer; called with the bus ready.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [3:0] prot,
                      output logic [31:0] rdata, output int waits,
                      output logic resp_w, output logic resp_d);
    addr_phase(wr, addr, size, prot);
    step();
    idle_bus();
    hwdata = wdata;
    waits  = 0;
    resp_w = 1'b0;
    while (hready !== 1'b1 && waits < 16) begin
      resp_w = resp_w | hresp;
      step();
      waits++;
    end
    rdata  = hrdata;
    resp_d = hresp;
    step();
    hwdata = 32'h0;
  endtask

  logic [31:0] rd;
  int          w;
  logic        rw, rdp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    which   = 0;
    hresetn = 1'b0;
    hwdata  = 32'h0;
    idle_bus();

    // 1. reset with random bus activity
    for (int i = 0; i < 2; i++) begin
      hsel   = 1'($urandom);
      haddr  = $urandom;
      hwrite = 1'($urandom);
      htrans = 2'($urandom);
      hsize  = 3'($urandom);
      hwdata = $urandom;
      which  = int'($urandom_range(0, 2));
      step();
      chk($sformatf("rst%0d_rdy_u0", i), {31'b0, rdy0}, 32'd1);
      chk($sformatf("rst%0d_resp_u0", i), {31'b0, resp0}, 32'd0);
      chk($sformatf("rst%0d_data_u0", i), rdata0, 32'h0);
      chk($sformatf("rst%0d_rdy_u2", i), {31'b0, rdy2}, 32'd1);
      chk($sformatf("rst%0d_resp_u2", i), {31'b0, resp2}, 32'd0);
      chk($sformatf("rst%0d_data_u2", i), rdata2, 32'h0);
      chk($sformatf("rst%0d_rdy_u3", i), {31'b0, rdy3}, 32'd1);
      chk($sformatf("rst%0d_resp_u3", i), {31'b0, resp3}, 32'd0);
      chk($sformatf("rst%0d_data_u3", i), rdata3, 32'h0);
    end
    idle_bus();
    hwdata = 32'h0;
    which  = 0;
    @(negedge hclk);
    hresetn = 1'b1;
    step();
    chk("post_rst_idle_data", hrdata, 32'h0);
    chk("post_rst_idle_rdy", {31'b0, hready}, 32'd1);

    // 2. zero-wait write then back-to-back read of the same word
    addr_phase(1'b1, BASE + 32'h10, 3'd2, 4'b0011);
    step();
    chk("t2_wr_rdy", {31'b0, hready}, 32'd1);
    chk("t2_wr_resp", {31'b0, hresp}, 32'd0);
    hwdata = 32'hDEAD_BEEF;
    hwrite = 1'b0;
    step();
    chk("t2_rd_rdy", {31'b0, hready}, 32'd1);
    chk("t2_rd_resp", {31'b0, hresp}, 32'd0);
    chk("t2_rd_data", hrdata, 32'hDEAD_BEEF);
    idle_bus();
    hwdata = 32'h0;
    step();
    chk("t2_idle_data", hrdata, 32'h0);

    // 3. byte-lane writes
    xfer(1'b1, BASE + 32'h10, 3'd2, 32'h1122_3344, 4'b0011, rd, w, rw, rdp);
    chk("t3_word_waits", 32'(w), 32'd0);
    xfer(1'b1, BASE + 32'h13, 3'd0, 32'hAB5A_5A5A, 4'b0011, rd, w, rw, rdp);
    chk("t3_byte_resp", {31'b0, rdp}, 32'd0);
    xfer(1'b1, BASE + 32'h10, 3'd1, 32'h9999_5566, 4'b0011, rd, w, rw, rdp);
    chk("t3_half_resp", {31'b0, rdp}, 32'd0);
    xfer(1'b0, BASE + 32'h10, 3'd2, 32'h0, 4'b0011, rd, w, rw, rdp);
    chk("t3_readback", rd, 32'hAB22_5566);
    xfer(1'b0, BASE + 32'h12, 3'd0, 32'h0, 4'b0011, rd, w, rw, rdp);
    chk("t3_byte_read_full_bus", rd, 32'hAB22_5566);
    xfer(1'b1, BASE + 32'h3FC, 3'd2, 32'h0F0F_0F0F, 4'b0011, rd, w, rw, rdp);
    chk("t3_last_word_wr_resp", {31'b0, rdp}, 32'd0);
    xfer(1'b0, BASE + 32'h3FC, 3'd2, 32'h0, 4'b0011, rd, w, rw, rdp);
    chk("t3_last_word_rd", rd, 32'h0F0F_0F0F);

    // 5. error responses
    xfer(1'b0, BASE + 32'h400, 3'd2, 32'h0, 4'b0011, rd, w, rw, rdp);
    chk("t5_oor_waits", 32'(w), 32'd1);
    chk("t5_oor_resp1", {31'b0, rw}, 32'd1);
    chk("t5_oor_resp2", {31'b0, rdp}, 32'd1);
    xfer(1'b1, BASE + 32'h11, 3'd1, 32'h7777_7777, 4'b0011, rd, w, rw, rdp);
    chk("t5_misal_waits", 32'(w), 32'd1);
    chk("t5_misal_resp1", {31'b0, rw}, 32'd1);
    chk("t5_misal_resp2", {31'b0, rdp}, 32'd1);
    xfer(1'b0, BASE - 32'h4, 3'd2, 32'h0, 4'b0011, rd, w, rw, rdp);
    chk("t5_below_base_resp", {31'b0, rdp}, 32'd1);
    xfer(1'b1, BASE + 32'h18, 3'd3, 32'h6666_6666, 4'b0011, rd, w, rw, rdp);
    chk("t5_oversize_resp", {31'b0, rdp}, 32'd1);
    xfer(1'b0, BASE + 32'h10, 3'd2, 32'h0, 4'b0011, rd, w, rw, rdp);
    chk("t5_mem_unchanged", rd, 32'hAB22_5566);

    // 5b. new NONSEQ presented during the error response
    addr_phase(1'b0, BASE + 32'h400, 3'd2, 4'b0011);
    step();
    addr_phase(1'b0, BASE + 32'h10, 3'd2, 4'b0011);
    chk("t5_err1_rdy", {31'b0, hready}, 32'd0);
    chk("t5_err1_resp", {31'b0, hresp}, 32'd1);
    step();
    chk("t5_err2_rdy", {31'b0, hready}, 32'd1);
    chk("t5_err2_resp", {31'b0, hresp}, 32'd1);
    step();
    idle_bus();
    chk("t5_after_err_rdy", {31'b0, hready}, 32'd1);
    chk("t5_after_err_resp", {31'b0, hresp}, 32'd0);
    chk("t5_after_err_data", hrdata, 32'hAB22_5566);
    step();

    // user-mode write: error only with the privilege feature enabled
    xfer(1'b1, BASE + 32'h18, 3'd2, 32'h4444_4444, 4'b0001, rd, w, rw, rdp);
    chk("priv_user_wr_resp", {31'b0, rdp}, {31'b0, USER_WR_ERR});
    xfer(1'b0, BASE + 32'h18, 3'd0, 32'h0, 4'b0000, rd, w, rw, rdp);
    chk("priv_user_rd_resp", {31'b0, rdp}, 32'd0);

    // 4. two wait states, pipelined NONSEQ held through the stall
    which = 1;
    step();
    xfer(1'b1, BASE + 32'h10, 3'd2, 32'h0BAD_F00D, 4'b0011, rd, w, rw, rdp);
    chk("t4_wr_waits", 32'(w), 32'd2);
    chk("t4_wr_wait_resp", {31'b0, rw}, 32'd0);
    xfer(1'b1, BASE + 32'h14, 3'd2, 32'h55AA_55AA, 4'b0011, rd, w, rw, rdp);
    chk("t4_wr2_waits", 32'(w), 32'd2);
    addr_phase(1'b0, BASE + 32'h10, 3'd2, 4'b0011);
    step();
    addr_phase(1'b0, BASE + 32'h14, 3'd2, 4'b0011);
    chk("t4_a_w1_rdy", {31'b0, hready}, 32'd0);
    chk("t4_a_w1_data", hrdata, 32'h0);
    step();
    chk("t4_a_w2_rdy", {31'b0, hready}, 32'd0);
    step();
    chk("t4_a_data_rdy", {31'b0, hready}, 32'd1);
    chk("t4_a_data", hrdata, 32'h0BAD_F00D);
    chk("t4_a_resp", {31'b0, hresp}, 32'd0);
    step();
    idle_bus();
    chk("t4_b_w1_rdy", {31'b0, hready}, 32'd0);
    step();
    chk("t4_b_w2_rdy", {31'b0, hready}, 32'd0);
    step();
    chk("t4_b_data_rdy", {31'b0, hready}, 32'd1);
    chk("t4_b_data", hrdata, 32'h55AA_55AA);
    step();
    chk("t4_idle_rdy", {31'b0, hready}, 32'd1);

    // 6. reset in the middle of a wait-stated write
    which = 2;
    step();
    xfer(1'b1, BASE + 32'h20, 3'd2, 32'hCAFE_F00D, 4'b0011, rd, w, rw, rdp);
    chk("t6_prior_wr_waits", 32'(w), 32'd3);
    addr_phase(1'b1, BASE + 32'h20, 3'd2, 4'b0011);
    step();
    idle_bus();
    hwdata = 32'h1234_5678;
    step();
    chk("t6_w2_rdy", {31'b0, rdy3}, 32'd0);
    #1 hresetn = 1'b0;
    #1;
    chk("t6_rst_rdy", {31'b0, rdy3}, 32'd1);
    chk("t6_rst_resp", {31'b0, resp3}, 32'd0);
    chk("t6_rst_data", rdata3, 32'h0);
    @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    hwdata  = 32'h0;
    step();
    xfer(1'b0, BASE + 32'h20, 3'd2, 32'h0, 4'b0011, rd, w, rw, rdp);
    chk("t6_rd_after_abort", rd, 32'hCAFE_F00D);
    chk("t6_rd_waits", 32'(w), 32'd3);

    // memory survives reset on the other instance too
    which = 0;
    step();
    xfer(1'b0, BASE + 32'h10, 3'd2, 32'h0, 4'b0011, rd, w, rw, rdp);
    chk("mem_kept_through_reset", rd, 32'hAB22_5566);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
